// File: rtl/regfile_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_pkg
// Description : Shared types and constants for the register-file dump
//               reader: dump FSM state encoding, architectural register
//               constants and the register index type.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_dump_pkg;

    localparam int c_ADDRESS_WIDTH = 5;
    localparam int c_REG_A0        = 10;
    localparam int c_NUM_ARCH_REGS = 32;

    // State encoding kept as explicit 2-bit constants so the enum values
    // are stable across tools and visible in waveforms as plain numbers.
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        STREAM = c_ST_STREAM,
        DONE   = c_ST_DONE
    } dump_state_t;

    typedef logic [c_ADDRESS_WIDTH-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_if
// Description : valid/ready stream carrying (index, value) beats from the
//               dump reader to its consumer.
//               out_valid/out_data/out_idx/out_last : producer -> consumer
//               out_ready                           : consumer -> producer
//               master = producer (regfile_dump), slave = consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dump_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);

    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic [ADDRESS_WIDTH-1:0] out_idx;
    logic                     out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump
// Description : Sequentially reads registers 0 (or 1) .. NUM_REGS-1 through
//               a combinational regfile read port and streams each one out
//               as an (index, value) beat.
//   clk, rst          : clock, synchronous active-high reset
//   start, skip_x0    : begin a dump (IDLE only); skip_x0 starts at index 1
//   rd_addr, rd_data  : regfile read port (data is combinational on addr)
//   dump (master)     : out_valid/out_ready/out_data/out_idx/out_last stream
//   busy              : high while beats are being streamed
//   done              : one-cycle pulse after the last beat is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     start,
    input  wire logic                     skip_x0,
    output logic      [ADDRESS_WIDTH-1:0] rd_addr,
    input  wire logic [DATA_WIDTH-1:0]    rd_data,
    regfile_dump_if.master                dump,
    output logic                          busy,
    output logic                          done
);

    localparam logic [ADDRESS_WIDTH-1:0] c_LAST_IDX = ADDRESS_WIDTH'(NUM_REGS - 1);

    dump_state_t              r_state;
    logic                     r_valid;
    logic                     r_last;
    logic                     r_busy;
    logic                     r_done;
    logic [ADDRESS_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0]    r_data;

    logic [ADDRESS_WIDTH-1:0] w_first;
    logic [ADDRESS_WIDTH-1:0] w_next;
    logic [ADDRESS_WIDTH-1:0] w_rd_addr;
    logic                     w_fire;

    assign w_first = skip_x0 ? ADDRESS_WIDTH'(1) : '0;
    // Wrap to 0 on the last beat so the read address always stays in range.
    assign w_next  = r_last ? '0 : r_idx + ADDRESS_WIDTH'(1);
    assign w_fire  = r_valid & dump.out_ready;

    // The read address always points at the index the next capture edge
    // will latch, so the regfile data is ready in the same cycle.
    always_comb begin
        w_rd_addr = '0;
        case (r_state)
            IDLE:    w_rd_addr = start ? w_first : '0;
            STREAM:  w_rd_addr = w_next;
            default: w_rd_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_data  <= rd_data;
                        r_idx   <= w_first;
                        r_valid <= 1'b1;
                        r_last  <= (w_first == c_LAST_IDX);
                        r_busy  <= 1'b1;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    // Without a handshake every output register holds.
                    if (w_fire) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx  <= w_next;
                            r_data <= rd_data;
                            r_last <= (w_next == c_LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_addr        = w_rd_addr;
    assign dump.out_valid = r_valid;
    assign dump.out_data  = r_data;
    assign dump.out_idx   = r_idx;
    assign dump.out_last  = r_last;
    assign busy           = r_busy;
    assign done           = r_done;

    // A single-register file has no index 1 to start from.
    generate
        if (NUM_REGS == 1) begin : g_single_reg_check
            a_no_skip_single : assert property (
                @(posedge clk) disable iff (rst)
                (r_state == IDLE && start) |-> !skip_x0
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump
// Description : Directed self-checking bench for regfile_dump with a
//               behavioural regfile preloaded to reg[i] = 0x1000 + i.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_dump;

    localparam int c_AW = 5;
    localparam int c_DW = 32;
    localparam int c_N  = 32;

    logic            clk     = 1'b0;
    logic            rst     = 1'b1;
    logic            start   = 1'b0;
    logic            skip_x0 = 1'b0;
    logic [c_AW-1:0] rd_addr;
    logic [c_DW-1:0] rd_data;
    logic            busy;
    logic            done;
    logic [c_DW-1:0] rf [0:c_N-1];

    int n_vec = 0;
    int n_err = 0;

    // Beats collected by run_dump.
    int              nb;
    int              b_idx  [0:63];
    logic [c_DW-1:0] b_data [0:63];
    logic            b_last [0:63];
    int              busy_cnt, done_cnt, last_cyc, done_cyc, hold_bad, rd_bad;
    bit              timed_out;

    regfile_dump_if #(.ADDRESS_WIDTH(c_AW), .DATA_WIDTH(c_DW)) dump_if ();

    regfile_dump #(.ADDRESS_WIDTH(c_AW), .DATA_WIDTH(c_DW), .NUM_REGS(c_N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .skip_x0 (skip_x0),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dump    (dump_if),
        .busy    (busy),
        .done    (done)
    );

    assign rd_data = rf[rd_addr];

    always #5 clk = ~clk;

    task automatic reload_rf();
        for (int i = 0; i < c_N; i++) rf[i] = 32'h1000 + i;
    endtask

    // Starts a dump and records beats until done has been seen (plus a few
    // idle cycles). ready_mode 0: always ready, 1: ready pattern 1,0,0,1.
    task automatic run_dump(input bit skip, input int ready_mode,
                            input bit do_writes, input bit repulse);
        bit              seen_done;
        int              extra;
        bit              pv, pr, rdy;
        logic [c_AW-1:0] pidx;
        logic [c_DW-1:0] pdata;
        nb = 0; busy_cnt = 0; done_cnt = 0; last_cyc = -1; done_cyc = -2;
        hold_bad = 0; rd_bad = 0; timed_out = 1'b0;
        seen_done = 1'b0; extra = 0; pv = 1'b0; pr = 1'b0; pidx = '0; pdata = '0;
        @(negedge clk);
        skip_x0 = skip;
        start   = 1'b1;
        dump_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                seen_done = 1'b1;
            end
            if (pv && !pr && (!dump_if.out_valid || dump_if.out_idx != pidx ||
                              dump_if.out_data != pdata))
                hold_bad++;
            if (dump_if.out_valid) begin
                if (dump_if.out_last) begin
                    if (int'(rd_addr) >= c_N) rd_bad++;
                end else if (rd_addr != dump_if.out_idx + 5'd1) begin
                    rd_bad++;
                end
            end
            rdy = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            dump_if.out_ready = rdy;
            if (dump_if.out_valid && rdy) begin
                b_idx[nb]  = int'(dump_if.out_idx);
                b_data[nb] = dump_if.out_data;
                b_last[nb] = dump_if.out_last;
                nb++;
                if (dump_if.out_last) last_cyc = cyc;
                if (do_writes) begin
                    if (dump_if.out_idx == 5'd5) rf[20] = 32'hDEADBEEF;
                    if (dump_if.out_idx == 5'd4) rf[3]  = 32'h0000CAFE;
                end
            end
            start = 1'b0;
            if (repulse && (cyc == 10 || done)) start = 1'b1;
            pv    = dump_if.out_valid;
            pr    = rdy;
            pidx  = dump_if.out_idx;
            pdata = dump_if.out_data;
            if (seen_done) extra++;
            if (extra > 6) break;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen_done) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dump_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (dump_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", dump_if.out_valid); end
        n_vec++; if (dump_if.out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", dump_if.out_data); end
        n_vec++; if (dump_if.out_idx !== 5'd0) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", dump_if.out_idx); end
        n_vec++; if (dump_if.out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b expected 0", dump_if.out_last); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        rst = 1'b0;
    endtask

    task automatic test_full_dump();
        reload_rf();
        run_dump(1'b0, 0, 1'b0, 1'b0);
        n_vec++; if (timed_out) begin n_err++; $display("FAIL full_timeout: got no done expected done"); end
        n_vec++; if (nb != 32) begin n_err++; $display("FAIL full_beats: got %0d expected 32", nb); end
        for (int i = 0; i < 32 && i < nb; i++) begin
            n_vec++; if (b_idx[i] != i) begin n_err++; $display("FAIL full_idx[%0d]: got %0d expected %0d", i, b_idx[i], i); end
            n_vec++; if (b_data[i] !== 32'h1000 + i) begin n_err++; $display("FAIL full_data[%0d]: got %h expected %h", i, b_data[i], 32'h1000 + i); end
            n_vec++; if (b_last[i] !== (i == 31)) begin n_err++; $display("FAIL full_last[%0d]: got %b expected %b", i, b_last[i], (i == 31)); end
        end
        n_vec++; if (busy_cnt != 32) begin n_err++; $display("FAIL full_busy_cycles: got %0d expected 32", busy_cnt); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
        n_vec++; if (done_cyc != last_cyc + 1) begin n_err++; $display("FAIL full_done_timing: got cycle %0d expected %0d", done_cyc, last_cyc + 1); end
        n_vec++; if (rd_bad != 0) begin n_err++; $display("FAIL full_rd_addr: got %0d bad addresses expected 0", rd_bad); end
    endtask

    task automatic test_skip_x0();
        reload_rf();
        run_dump(1'b1, 0, 1'b0, 1'b0);
        n_vec++; if (timed_out) begin n_err++; $display("FAIL skip_timeout: got no done expected done"); end
        n_vec++; if (nb != 31) begin n_err++; $display("FAIL skip_beats: got %0d expected 31", nb); end
        for (int i = 0; i < 31 && i < nb; i++) begin
            n_vec++; if (b_idx[i] != i + 1) begin n_err++; $display("FAIL skip_idx[%0d]: got %0d expected %0d", i, b_idx[i], i + 1); end
            n_vec++; if (b_data[i] !== 32'h1001 + i) begin n_err++; $display("FAIL skip_data[%0d]: got %h expected %h", i, b_data[i], 32'h1001 + i); end
            n_vec++; if (b_last[i] !== (i == 30)) begin n_err++; $display("FAIL skip_last[%0d]: got %b expected %b", i, b_last[i], (i == 30)); end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL skip_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        reload_rf();
        run_dump(1'b0, 1, 1'b0, 1'b0);
        n_vec++; if (timed_out) begin n_err++; $display("FAIL bp_timeout: got no done expected done"); end
        n_vec++; if (nb != 32) begin n_err++; $display("FAIL bp_beats: got %0d expected 32", nb); end
        for (int i = 0; i < 32 && i < nb; i++) begin
            n_vec++; if (b_idx[i] != i) begin n_err++; $display("FAIL bp_idx[%0d]: got %0d expected %0d", i, b_idx[i], i); end
            n_vec++; if (b_data[i] !== 32'h1000 + i) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected %h", i, b_data[i], 32'h1000 + i); end
        end
        n_vec++; if (hold_bad != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", hold_bad); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_coherency();
        reload_rf();
        run_dump(1'b0, 0, 1'b1, 1'b0);
        n_vec++; if (nb != 32) begin n_err++; $display("FAIL coh_beats: got %0d expected 32", nb); end
        n_vec++; if (b_data[20] !== 32'hDEADBEEF) begin n_err++; $display("FAIL coh_late_write: got %h expected deadbeef", b_data[20]); end
        n_vec++; if (b_data[3] !== 32'h00001003) begin n_err++; $display("FAIL coh_early_write: got %h expected 00001003", b_data[3]); end
        n_vec++; if (b_data[5] !== 32'h00001005) begin n_err++; $display("FAIL coh_beat5: got %h expected 00001005", b_data[5]); end
        reload_rf();
    endtask

    task automatic test_reset_mid();
        bit found;
        int vcnt, dcnt;
        found = 1'b0; vcnt = 0; dcnt = 0;
        reload_rf();
        @(negedge clk);
        skip_x0 = 1'b0;
        start   = 1'b1;
        dump_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (dump_if.out_valid && dump_if.out_idx == 5'd12) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL rstmid_reach12: got no idx 12 expected idx 12"); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (dump_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", dump_if.out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_vec++; if (dump_if.out_idx !== 5'd0) begin n_err++; $display("FAIL rstmid_idx: got %0d expected 0", dump_if.out_idx); end
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (done) dcnt++;
            if (dump_if.out_valid) vcnt++;
            @(posedge clk);
            @(negedge clk);
        end
        n_vec++; if (dcnt != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dcnt); end
        n_vec++; if (vcnt != 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d valid cycles expected 0", vcnt); end
        run_dump(1'b0, 0, 1'b0, 1'b0);
        n_vec++; if (nb != 32) begin n_err++; $display("FAIL rstmid_restart_beats: got %0d expected 32", nb); end
        n_vec++; if (b_idx[0] != 0) begin n_err++; $display("FAIL rstmid_restart_idx: got %0d expected 0", b_idx[0]); end
        n_vec++; if (b_data[0] !== 32'h00001000) begin n_err++; $display("FAIL rstmid_restart_data: got %h expected 00001000", b_data[0]); end
    endtask

    task automatic test_back_to_back();
        reload_rf();
        run_dump(1'b0, 0, 1'b0, 1'b1);
        n_vec++; if (timed_out) begin n_err++; $display("FAIL repulse_timeout: got no done expected done"); end
        n_vec++; if (nb != 32) begin n_err++; $display("FAIL repulse_beats: got %0d expected 32", nb); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL repulse_done_pulses: got %0d expected 1", done_cnt); end
        n_vec++; if (busy_cnt != 32) begin n_err++; $display("FAIL repulse_busy_cycles: got %0d expected 32", busy_cnt); end
        n_vec++; if (nb > 31 && b_idx[31] != 31) begin n_err++; $display("FAIL repulse_last_idx: got %0d expected 31", b_idx[31]); end
    endtask

    initial begin
        dump_if.out_ready = 1'b0;
        reload_rf();
        test_reset();
        test_full_dump();
        test_skip_x0();
        test_backpressure();
        test_coherency();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
